// File: rtl/bf16_vector_processing_block.sv
// bf16 SIMD block: in-order, two-cycle execution of vector load/store and lane-wise
// bf16 add/multiply against a 256-entry vector register file.
module bf16_vector_processing_block #(
    parameter int unsigned LANES      = 32,
    parameter int unsigned NUM_REGS   = 256,
    parameter int unsigned IMEM_DEPTH = 65536
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [31:0]         instructions [IMEM_DEPTH],
    input  logic [16*LANES-1:0] load_data,
    output logic [15:0]         load_addr,
    output logic [15:0]         write_addr,
    output logic [16*LANES-1:0] write_data,
    output logic                load_ctrl,
    output logic                write_ctrl
);

    localparam int unsigned W = 16 * LANES;

    localparam logic [7:0] OpHalt  = 8'h00;
    localparam logic [7:0] OpAdd   = 8'h01;
    localparam logic [7:0] OpMul   = 8'h02;
    localparam logic [7:0] OpStore = 8'h10;
    localparam logic [7:0] OpLoad  = 8'h20;

    localparam logic PhIssue = 1'b0;
    localparam logic PhDone  = 1'b1;

    localparam logic [15:0] QNan = 16'h7FC0;

    logic [15:0]  pc_q, pc_d;
    logic         phase_q, phase_d;
    logic [W-1:0] regs_q [NUM_REGS];

    logic [31:0]  instr;
    logic [7:0]   opcode, rd, ra, rb;
    logic [W-1:0] vec_a, vec_b, add_res, mul_res, rf_wdata;
    logic         rf_we;

    function automatic logic is_nan(input logic [15:0] h);
        return (h[14:7] == 8'hFF) && (h[6:0] != 7'd0);
    endfunction

    // mant is the normalised 8-bit significand (hidden bit at mant[7]).
    function automatic logic [15:0] bf16_round(input logic              sign,
                                               input logic signed [10:0] exp,
                                               input logic [7:0]         mant,
                                               input logic               guard,
                                               input logic               sticky);
        logic [15:0]       res;
        logic [8:0]        m_r;
        logic signed [10:0] e_r;
        m_r = {1'b0, mant} + {8'd0, guard & (sticky | mant[0])};
        e_r = exp;
        if (m_r[8]) begin
            m_r = 9'h080;
            e_r = exp + 11'sd1;
        end
        if (e_r >= 11'sd255) begin
            res = {sign, 15'h7F80};
        end else if (e_r <= 11'sd0) begin
            res = {sign, 15'h0000};
        end else begin
            res = {sign, e_r[7:0], m_r[6:0]};
        end
        return res;
    endfunction

    function automatic logic [15:0] bf16_mul(input logic [15:0] a, input logic [15:0] b);
        logic [15:0]        res;
        logic               sign;
        logic [15:0]        ma, mb, prod;
        logic signed [10:0] e;
        sign = a[15] ^ b[15];
        ma   = {8'd0, 1'b1, a[6:0]};
        mb   = {8'd0, 1'b1, b[6:0]};
        prod = ma * mb;
        e    = $signed({3'b000, a[14:7]}) + $signed({3'b000, b[14:7]});
        if (is_nan(a) || is_nan(b)) begin
            res = QNan;
        end else if ((a[14:7] == 8'hFF && b[14:7] == 8'h00) ||
                     (a[14:7] == 8'h00 && b[14:7] == 8'hFF)) begin
            res = QNan;
        end else if (a[14:7] == 8'hFF || b[14:7] == 8'hFF) begin
            res = {sign, 15'h7F80};
        end else if (a[14:7] == 8'h00 || b[14:7] == 8'h00) begin
            res = {sign, 15'h0000};
        end else if (prod[15]) begin
            res = bf16_round(sign, e - 11'sd126, prod[15:8], prod[7], |prod[6:0]);
        end else begin
            res = bf16_round(sign, e - 11'sd127, prod[14:7], prod[6], |prod[5:0]);
        end
        return res;
    endfunction

    function automatic logic [15:0] bf16_add(input logic [15:0] a, input logic [15:0] b);
        logic [15:0]        res, x, y;
        logic [7:0]         d;
        logic [10:0]        mx, my;
        logic [21:0]        sh;
        logic [11:0]        s;
        logic [3:0]         lz;
        logic signed [10:0] e;
        res = '0;
        x   = a;
        y   = b;
        my  = '0;
        sh  = '0;
        s   = '0;
        lz  = '0;
        if (is_nan(a) || is_nan(b)) begin
            res = QNan;
        end else if (a[14:7] == 8'hFF && b[14:7] == 8'hFF) begin
            res = (a[15] == b[15]) ? a : QNan;
        end else if (a[14:7] == 8'hFF) begin
            res = a;
        end else if (b[14:7] == 8'hFF) begin
            res = b;
        end else if (a[14:7] == 8'h00 && b[14:7] == 8'h00) begin
            res = {a[15] & b[15], 15'h0000};
        end else if (a[14:7] == 8'h00) begin
            res = b;
        end else if (b[14:7] == 8'h00) begin
            res = a;
        end else begin
            if (a[14:0] < b[14:0]) begin
                x = b;
                y = a;
            end
            d  = x[14:7] - y[14:7];
            // Significands carry guard/round/sticky below bit 3.
            mx = {1'b1, x[6:0], 3'b000};
            if (d > 8'd11) begin
                my = 11'd1;
            end else begin
                sh = {1'b1, y[6:0], 14'd0} >> d;
                my = {sh[21:12], sh[11] | (|sh[10:0])};
            end
            s = (x[15] == y[15]) ? ({1'b0, mx} + {1'b0, my}) : ({1'b0, mx} - {1'b0, my});
            e = $signed({3'b000, x[14:7]});
            if (s == 12'd0) begin
                res = 16'h0000;
            end else begin
                if (s[11]) begin
                    s = {1'b0, s[11:2], s[1] | s[0]};
                    e = e + 11'sd1;
                end else begin
                    for (int i = 0; i <= 10; i++) begin
                        if (s[i]) lz = 4'(10 - i);
                    end
                    s = s << lz;
                    e = e - $signed({7'd0, lz});
                end
                res = bf16_round(x[15], e, s[10:3], s[2], |s[1:0]);
            end
        end
        return res;
    endfunction

    assign instr  = instructions[pc_q];
    assign opcode = instr[31:24];
    assign rd     = instr[23:16];
    assign ra     = instr[15:8];
    assign rb     = instr[7:0];
    assign vec_a  = regs_q[ra];
    assign vec_b  = regs_q[rb];

    always_comb begin
        add_res = '0;
        mul_res = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            add_res[16*i +: 16] = bf16_add(vec_a[16*i +: 16], vec_b[16*i +: 16]);
            mul_res[16*i +: 16] = bf16_mul(vec_a[16*i +: 16], vec_b[16*i +: 16]);
        end
    end

    always_comb begin
        rf_we    = 1'b0;
        rf_wdata = '0;
        if (phase_q == PhDone) begin
            case (opcode)
                OpLoad: begin
                    rf_we    = 1'b1;
                    rf_wdata = load_data;
                end
                OpAdd: begin
                    rf_we    = 1'b1;
                    rf_wdata = add_res;
                end
                OpMul: begin
                    rf_we    = 1'b1;
                    rf_wdata = mul_res;
                end
                default: ;
            endcase
        end
    end

    // HALT never leaves the issue phase, so PC freezes there.
    always_comb begin
        pc_d    = pc_q;
        phase_d = phase_q;
        if (phase_q == PhIssue) begin
            if (opcode != OpHalt) phase_d = PhDone;
        end else begin
            phase_d = PhIssue;
            pc_d    = pc_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= '0;
            phase_q <= PhIssue;
        end else begin
            pc_q    <= pc_d;
            phase_q <= phase_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (rf_we) begin
            regs_q[rd] <= rf_wdata;
        end
    end

    // Gated by reset_n so the memory port goes idle the moment reset asserts.
    always_comb begin
        load_ctrl  = 1'b0;
        load_addr  = '0;
        write_ctrl = 1'b0;
        write_addr = '0;
        write_data = '0;
        if (reset_n) begin
            if (opcode == OpLoad) begin
                load_ctrl = 1'b1;
                load_addr = instr[15:0];
            end
            if (opcode == OpStore) begin
                write_ctrl = 1'b1;
                write_addr = instr[15:0];
                write_data = regs_q[rd];
            end
        end
    end

endmodule

// File: tb/tb_bf16_vector_processing_block.sv
// Bench for bf16_vector_processing_block: cycle-level port checks, a special-value
// table, async reset mid-store, HALT, and random programs against an ISA-level model.
module tb_bf16_vector_processing_block;

    localparam int LANES = 32;
    localparam int W     = 16 * LANES;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [31:0]  imem [65536];
    logic [W-1:0] dmem [65536];
    logic [W-1:0] load_data, write_data;
    logic [15:0]  load_addr, write_addr;
    logic         load_ctrl, write_ctrl;

    logic         pl_en = 1'b0;
    logic [15:0]  pl_addr = '0;
    logic [W-1:0] pl_data = '0;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        is_mul;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl [$];

    always #5 clk = ~clk;

    assign load_data = dmem[load_addr];

    always @(posedge clk) begin
        if (pl_en) dmem[pl_addr] <= pl_data;
        else if (write_ctrl) dmem[write_addr] <= write_data;
    end

    bf16_vector_processing_block dut (
        .clock        (clk),
        .reset_n      (reset_n),
        .instructions (imem),
        .load_data    (load_data),
        .load_addr    (load_addr),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .load_ctrl    (load_ctrl),
        .write_ctrl   (write_ctrl)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] splat(input logic [15:0] h);
        return {LANES{h}};
    endfunction

    function automatic logic [31:0] enc_ld(input logic [7:0] r, input logic [15:0] a);
        return {8'h20, r, a};
    endfunction
    function automatic logic [31:0] enc_st(input logic [7:0] r, input logic [15:0] a);
        return {8'h10, r, a};
    endfunction
    function automatic logic [31:0] enc_alu(input logic is_mul, input logic [7:0] d,
                                            input logic [7:0] a, input logic [7:0] b);
        return {is_mul ? 8'h02 : 8'h01, d, a, b};
    endfunction

    // Reference arithmetic: exact value in double precision, then one rounding to bf16.
    function automatic logic m_nan(input logic [15:0] h);
        return h[14:7] == 8'hFF && h[6:0] != 7'd0;
    endfunction
    function automatic logic m_inf(input logic [15:0] h);
        return h[14:7] == 8'hFF && h[6:0] == 7'd0;
    endfunction
    function automatic logic m_zero(input logic [15:0] h);
        return h[14:7] == 8'h00;
    endfunction

    function automatic real to_real(input logic [15:0] h);
        logic [63:0] d;
        if (m_zero(h)) return 0.0;
        d = {h[15], 11'(int'(h[14:7]) - 127 + 1023), h[6:0], 45'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [15:0] from_real(input real x);
        logic [63:0] d;
        logic [8:0]  m;
        int          e;
        logic        s;
        d = $realtobits(x);
        s = d[63];
        e = int'(d[62:52]) - 1023;
        m = {2'b01, d[51:45]};
        if (d[44] && ((|d[43:0]) || d[45])) m = m + 9'd1;
        if (m[8]) begin
            m = 9'h080;
            e = e + 1;
        end
        if (e > 127) return {s, 15'h7F80};
        if (e < -126) return {s, 15'h0000};
        return {s, 8'(e + 127), m[6:0]};
    endfunction

    function automatic logic [15:0] m_add(input logic [15:0] a, input logic [15:0] b);
        real r;
        if (m_nan(a) || m_nan(b)) return 16'h7FC0;
        if (m_inf(a) && m_inf(b)) return (a[15] == b[15]) ? a : 16'h7FC0;
        if (m_inf(a)) return a;
        if (m_inf(b)) return b;
        r = to_real(a) + to_real(b);
        if (r == 0.0) return (m_zero(a) && m_zero(b) && a[15] && b[15]) ? 16'h8000 : 16'h0000;
        return from_real(r);
    endfunction

    function automatic logic [15:0] m_mul(input logic [15:0] a, input logic [15:0] b);
        logic s;
        s = a[15] ^ b[15];
        if (m_nan(a) || m_nan(b)) return 16'h7FC0;
        if ((m_inf(a) && m_zero(b)) || (m_zero(a) && m_inf(b))) return 16'h7FC0;
        if (m_inf(a) || m_inf(b)) return {s, 15'h7F80};
        if (m_zero(a) || m_zero(b)) return {s, 15'h0000};
        return from_real(to_real(a) * to_real(b));
    endfunction

    function automatic logic [W-1:0] m_vec(input logic is_mul, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            r[16*i +: 16] = is_mul ? m_mul(x[16*i +: 16], y[16*i +: 16])
                                   : m_add(x[16*i +: 16], y[16*i +: 16]);
        end
        return r;
    endfunction

    function automatic logic [15:0] rand_bf16();
        int k;
        k = $urandom_range(0, 15);
        if (k == 0) begin
            case ($urandom_range(0, 5))
                0: return 16'h0000;
                1: return 16'h8000;
                2: return 16'h7F80;
                3: return 16'hFF80;
                4: return 16'h7FC0;
                default: return 16'h0003;
            endcase
        end
        if (k < 9) return {1'($urandom), 8'($urandom_range(118, 136)), 7'($urandom)};
        return {1'($urandom), 8'($urandom_range(1, 254)), 7'($urandom)};
    endfunction

    task automatic preload(input logic [15:0] a, input logic [W-1:0] d);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 128; i++) imem[i] = 32'h0;
    endtask

    // Releases reset on a falling edge; afterwards the bench sits inside cycle 0.
    task automatic release_reset();
        @(negedge clk);
        reset_n = 1'b1;
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] a_vec, b_vec, got_vec, exp_wd;
        logic [W-1:0] mreg [16];
        logic [15:0]  got, exp_la, exp_wa;
        logic         exp_lc, exp_wc;
        int           idx;

        for (int i = 0; i < 65536; i++) imem[i] = 32'h0;

        // Basic program with rounding check, cycle-exact port timing and HALT.
        clear_prog();
        imem[0] = enc_ld(8'd0, 16'd0);
        imem[1] = enc_ld(8'd1, 16'd1);
        imem[2] = enc_ld(8'd2, 16'd2);
        imem[3] = enc_alu(1'b1, 8'd3, 8'd0, 8'd1);
        imem[4] = enc_alu(1'b0, 8'd4, 8'd3, 8'd2);
        imem[5] = enc_st(8'd4, 16'd3);
        imem[6] = 32'h0000_0000;
        imem[7] = enc_st(8'd0, 16'd9);
        preload(16'd0, splat(16'h3E4D));
        preload(16'd1, splat(16'h4000));
        preload(16'd2, splat(16'h3E4D));
        preload(16'd3, '0);
        preload(16'd9, splat(16'hABCD));
        #1;
        check("reset_ctl", {load_ctrl, load_addr, write_ctrl, write_addr}, '0);
        check("reset_wdata", write_data, '0);
        release_reset();
        for (int c = 0; c < 36; c++) begin
            idx    = (c / 2 > 6) ? 6 : c / 2;
            exp_lc = idx < 3;
            exp_la = (idx < 3) ? 16'(idx) : 16'd0;
            exp_wc = idx == 5;
            exp_wa = (idx == 5) ? 16'd3 : 16'd0;
            exp_wd = (idx == 5) ? splat(16'h3F1A) : '0;
            check($sformatf("ctl_c%0d", c), {load_ctrl, load_addr, write_ctrl, write_addr},
                  {exp_lc, exp_la, exp_wc, exp_wa});
            check($sformatf("wdata_c%0d", c), write_data, exp_wd);
            step();
        end
        check("mem3", dmem[3], splat(16'h3F1A));
        check("mem9_after_halt", dmem[9], splat(16'hABCD));

        // Special values, one table entry per lane.
        tbl.push_back('{16'h3F80, 16'hBF80, 1'b0, 16'h0000});
        tbl.push_back('{16'h7F80, 16'hFF80, 1'b0, 16'h7FC0});
        tbl.push_back('{16'h7F00, 16'h7F00, 1'b1, 16'h7F80});
        tbl.push_back('{16'h0080, 16'h0080, 1'b1, 16'h0000});
        tbl.push_back('{16'h3F80, 16'h4049, 1'b1, 16'h4049});
        tbl.push_back('{16'h3F80, 16'hC2F7, 1'b1, 16'hC2F7});
        tbl.push_back('{16'h3F80, 16'h0080, 1'b1, 16'h0080});
        tbl.push_back('{16'h3ECD, 16'h3E4D, 1'b0, 16'h3F1A});
        tbl.push_back('{16'h3E4D, 16'h4000, 1'b1, 16'h3ECD});
        tbl.push_back('{16'h7F80, 16'h3F80, 1'b0, 16'h7F80});
        tbl.push_back('{16'hFF80, 16'hFF80, 1'b0, 16'hFF80});
        tbl.push_back('{16'h0000, 16'h7F80, 1'b1, 16'h7FC0});
        tbl.push_back('{16'h7FC1, 16'h3F80, 1'b0, 16'h7FC0});
        tbl.push_back('{16'h8000, 16'h3F80, 1'b1, 16'h8000});
        tbl.push_back('{16'h8000, 16'h8000, 1'b0, 16'h8000});
        tbl.push_back('{16'h0001, 16'h3F80, 1'b0, 16'h3F80});
        tbl.push_back('{16'h3F80, 16'h3F80, 1'b0, 16'h4000});
        tbl.push_back('{16'h3F80, 16'h3B80, 1'b0, 16'h3F80});
        tbl.push_back('{16'h3F81, 16'h3B80, 1'b0, 16'h3F82});
        tbl.push_back('{16'h3FC0, 16'h3FC0, 1'b1, 16'h4010});
        tbl.push_back('{16'h4000, 16'hC000, 1'b0, 16'h0000});
        tbl.push_back('{16'h3F80, 16'hC000, 1'b0, 16'hBF80});
        tbl.push_back('{16'hC000, 16'h4040, 1'b1, 16'hC0C0});
        tbl.push_back('{16'h7F7F, 16'h7F7F, 1'b0, 16'h7F80});
        tbl.push_back('{16'h3F80, 16'h3380, 1'b0, 16'h3F80});
        tbl.push_back('{16'h3F80, 16'hFF80, 1'b1, 16'hFF80});
        a_vec = '0;
        b_vec = '0;
        foreach (tbl[i]) begin
            a_vec[16*i +: 16] = tbl[i].a;
            b_vec[16*i +: 16] = tbl[i].b;
        end
        reset_n = 1'b0;
        clear_prog();
        imem[0] = enc_ld(8'd0, 16'd10);
        imem[1] = enc_ld(8'd1, 16'd11);
        imem[2] = enc_alu(1'b0, 8'd2, 8'd0, 8'd1);
        imem[3] = enc_alu(1'b1, 8'd3, 8'd0, 8'd1);
        imem[4] = enc_st(8'd2, 16'd12);
        imem[5] = enc_st(8'd3, 16'd13);
        preload(16'd10, a_vec);
        preload(16'd11, b_vec);
        release_reset();
        repeat (20) step();
        foreach (tbl[i]) begin
            got = tbl[i].is_mul ? dmem[13][16*i +: 16] : dmem[12][16*i +: 16];
            check($sformatf("tbl%0d_%h_%s_%h", i, tbl[i].a, tbl[i].is_mul ? "mul" : "add",
                            tbl[i].b), got, tbl[i].exp);
        end

        // Async reset during the issue phase of a STORE.
        reset_n = 1'b0;
        clear_prog();
        imem[0] = enc_st(8'd5, 16'd21);
        imem[1] = enc_ld(8'd5, 16'd0);
        imem[2] = enc_st(8'd5, 16'd20);
        preload(16'd0, splat(16'h1234));
        preload(16'd20, '0);
        release_reset();
        repeat (4) step();
        check("pre_rst_store", {write_ctrl, write_addr}, {1'b1, 16'd20});
        check("pre_rst_wdata", write_data, splat(16'h1234));
        reset_n = 1'b0;
        #1;
        check("async_rst_ctl", {load_ctrl, load_addr, write_ctrl, write_addr}, '0);
        check("async_rst_wdata", write_data, '0);
        repeat (2) step();
        release_reset();
        check("restart_pc0", {load_ctrl, write_ctrl, write_addr}, {1'b0, 1'b1, 16'd21});
        check("restart_regs_clear", write_data, '0);
        repeat (10) step();
        check("restart_mem20", dmem[20], splat(16'h1234));

        // Random programs against the ISA-level model.
        for (int it = 0; it < 3; it++) begin
            logic        op;
            logic [7:0]  d, a, b;
            reset_n = 1'b0;
            clear_prog();
            for (int r = 0; r < 16; r++) mreg[r] = '0;
            for (int r = 0; r < 8; r++) begin
                for (int l = 0; l < LANES; l++) a_vec[16*l +: 16] = rand_bf16();
                preload(16'(r), a_vec);
                imem[r] = enc_ld(8'(r), 16'(r));
                mreg[r] = a_vec;
            end
            for (int k = 0; k < 24; k++) begin
                op = 1'($urandom);
                d  = 8'($urandom_range(0, 15));
                a  = 8'($urandom_range(0, 15));
                b  = 8'($urandom_range(0, 15));
                imem[8 + k] = enc_alu(op, d, a, b);
                mreg[d] = m_vec(op, mreg[a], mreg[b]);
            end
            for (int r = 0; r < 16; r++) imem[32 + r] = enc_st(8'(r), 16'(100 + r));
            release_reset();
            repeat (110) step();
            for (int r = 0; r < 16; r++) begin
                got_vec = dmem[100 + r];
                check($sformatf("rand%0d_r%0d", it, r), got_vec, mreg[r]);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bf16_vector_processing_block.md
Name: bf16_vector_processing_block

Overview:
- Single-issue SIMD processing block. Executes a 32-bit instruction stream from an externally held instruction array.
- Moves 512-bit vectors (32 lanes of bf16) between main memory and an internal register file.
- Performs lane-wise bf16 add and multiply.
- Sits between the instruction store and the main-memory port; main memory answers loads combinationally and performs writes on `clock`.

Parameters:
- LANES, 32, number of 16-bit bf16 lanes per vector; vector width W = 16*LANES.
- NUM_REGS, 256, vector register count, addressed by an 8-bit index.
- IMEM_DEPTH, 65536, instruction array depth, addressed by a 16-bit PC.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- instructions  input  32 x IMEM_DEPTH (unpacked array)  instruction store, read combinationally at the PC.
- load_data  input  W  main-memory read data for load_addr.
- load_addr  output  16  main-memory read address.
- write_addr  output  16  main-memory write address.
- write_data  output  W  main-memory write data.
- load_ctrl  output  1  high while a load instruction is executing.
- write_ctrl  output  1  high while a store instruction is executing.

Interface: one clock; reset is asynchronous and active-low.

Behaviour:
- Instruction format:
  - [31:24] opcode
  - [23:16] rd (store: source register rs)
  - [15:0] 16-bit memory address (load/store)
  - or [15:8] ra, [7:0] rb (ALU)
- Opcodes:
  - 0x20 LOAD: reg[rd] <= load_data from mem[addr].
  - 0x10 STORE: mem[addr] <= reg[rs].
  - 0x01 ADD: reg[rd] <= reg[ra] + reg[rb], lane-wise.
  - 0x02 MUL: reg[rd] <= reg[ra] * reg[rb], lane-wise.
  - 0x00 HALT: PC holds.
  - Any other opcode: NOP.
- Reset (async, while reset_n=0):
  - PC=0, phase=0, all registers 0.
  - load_ctrl=0, write_ctrl=0, load_addr=0, write_addr=0, write_data=0.
- Timing: every instruction takes exactly 2 clock cycles.
  - Phase 0 = issue, phase 1 = complete.
  - On the rising edge ending phase 1: result written to rd (LOAD/ADD/MUL), PC increments, phase returns to 0.
  - PC wraps 0xFFFF -> 0.
- LOAD:
  - load_ctrl=1 and load_addr=instr[15:0], combinationally from the current instruction, for both phases.
  - load_data is sampled on the edge ending phase 1.
- STORE:
  - write_ctrl=1, write_addr=instr[15:0], write_data=reg[rs] for both phases.
  - Memory commits on the edge ending phase 1.
- Idle values: when not LOAD, load_ctrl=0 and load_addr=0; when not STORE, write_ctrl=0, write_addr=0, write_data=0.
- Sequential register semantics: an instruction reads the register values written by all earlier instructions, with no hazard stalls (each instruction retires before the next issues).
- ra == rb and rd == ra/rb are legal; sources are read before the write.
- bf16 arithmetic: 1 sign / 8 exponent / 7 mantissa bits, lane i = bits [16i+15:16i].
  - Round to nearest, ties to even.
  - Subnormal inputs and results flush to signed zero.
  - Overflow gives signed infinity.
  - Any NaN input, inf-inf, or 0*inf gives 0x7FC0.
  - inf+finite gives inf; x + (-x) gives +0.
- HALT: PC and phase hold; outputs idle until reset.

Test Plan:
- Reset then program LOAD r0<-m0, LOAD r1<-m1, LOAD r2<-m2 -> load_ctrl=1 with load_addr 0, 1, 2 at cycles 0-1, 2-3, 4-5; memory returns all-lanes 0x3E4D, 0x4000, 0x3E4D.
- Continue MUL r3=r0*r1, ADD r4=r3+r2, STORE r4->m3 -> at cycles 10-11 write_ctrl=1, write_addr=3, every lane of write_data = 0x3F1A. This checks rounding: truncation would give 0x3F19.
- Lane independence: per-lane distinct values, MUL of 0x3F80 (1.0) with vector X -> X unchanged in each lane; ADD of 0x3F80+0xBF80 -> 0x0000.
- Special values: ADD 0x7F80+0xFF80 -> 0x7FC0; MUL 0x7F00*0x7F00 -> 0x7F80; MUL 0x0080*0x0080 -> 0x0000.
- Assert reset_n mid-STORE (phase 0) -> write_ctrl drops to 0 immediately; after release execution restarts at PC 0 with registers cleared.
- HALT opcode 0x00 after one STORE -> outputs idle, PC frozen for 20+ cycles.
